// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   XLEN          : datapath / address width
//   INST_NOP      : instruction word presented to decode when nothing is valid
//   fetch_state_t : FETCH (normal operation) / DRAIN (discarding stale responses)
//   fetch_entry_t : one instruction-buffer slot {pc, inst, filled}
//   align_word()  : clears the two low address bits
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            filled;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Circular in-order instruction buffer. A slot is allocated when the memory
// grants a request (its PC is known then), and filled later by the next
// in-order response. The head slot is presented to decode once filled.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : free every slot (redirect)
//   alloc         : allocate tail slot with alloc_pc (count must be < DEPTH)
//   fill          : write fill_inst into the oldest allocated-unfilled slot;
//                   ignored when nothing is pending
//   pop           : free the head slot (caller only pops a filled head)
//   head_pc/inst  : head slot storage
//   head_filled   : head slot holds a returned instruction
//   count         : allocated slots, filled or not
//   pending       : allocated slots still waiting for their response
// -----------------------------------------------------------------------------
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_inst,
    input  logic            pop,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_inst,
    output logic            head_filled,
    output logic [CW-1:0]   count,
    output logic [CW-1:0]   pending
);

    fetch_entry_t   entry_q [DEPTH];
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [PW-1:0]  fill_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  pending_q;
    logic           fill_ok;

    logic [DEPTH-1:0] alloc_sel;
    logic [DEPTH-1:0] fill_sel;
    logic [DEPTH-1:0] pop_sel;

    // A response that arrives with nothing pending has no slot to land in.
    assign fill_ok = fill && (pending_q != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign alloc_sel[gi] = alloc   && (tail_q == PW'(gi));
            assign fill_sel[gi]  = fill_ok && (fill_q == PW'(gi));
            assign pop_sel[gi]   = pop     && (head_q == PW'(gi));
        end
    endgenerate

    // Fill never targets the head being popped (head is already filled) nor
    // the slot being allocated (it is free), so these writes never collide
    // except alloc+pop on a full buffer, where both clear the filled bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i].filled <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_sel[i]) begin
                    entry_q[i].pc     <= alloc_pc;
                    entry_q[i].filled <= 1'b0;
                end
                if (fill_sel[i]) begin
                    entry_q[i].inst   <= fill_inst;
                    entry_q[i].filled <= 1'b1;
                end
                if (pop_sel[i]) begin
                    entry_q[i].filled <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q    <= '0;
            tail_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            pending_q <= '0;
        end else begin
            if (alloc) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            if (fill_ok) begin
                fill_q <= fill_q + PW'(1);
            end
            count_q   <= count_q + CW'(alloc) - CW'(pop);
            pending_q <= pending_q + CW'(alloc) - CW'(fill_ok);
        end
    end

    assign head_pc     = entry_q[head_q].pc;
    assign head_inst   = entry_q[head_q].inst;
    assign head_filled = entry_q[head_q].filled;
    assign count       = count_q;
    assign pending     = pending_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the PC, issues
// word-aligned requests over a req/gnt + in-order rvalid interface, buffers
// returned instructions in fetch_buf and presents one per cycle to decode.
// A redirect flushes the buffer and, if responses are still in flight, moves
// to DRAIN to throw them away before fetching from the new target.
//
// Parameters:
//   RESET_PC  : PC loaded on reset
//   BUF_DEPTH : buffer slots (power of 2, >= 2); bounds outstanding+buffered
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   i_stall                 : decode cannot accept this cycle
//   i_redirect/_pc          : taken branch/jump and its target
//   o_imem_req/_addr        : fetch request and word address
//   i_imem_gnt              : request accepted
//   i_imem_rvalid/_rdata    : in-order response
//   o_valid/o_inst/o_pc/o_pc4 : instruction handed to decode
//
// Optional build macro FETCH_PERF_CNT_EN adds three wrapping 32-bit counters:
//   o_perf_fetched      : instructions popped by decode
//   o_perf_stall_cycles : cycles with o_valid held by i_stall
//   o_perf_flushed      : filled entries discarded plus responses dropped
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] o_perf_fetched,
    output logic [31:0] o_perf_stall_cycles,
    output logic [31:0] o_perf_flushed
`endif
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t    state_q, state_next;
    logic [XLEN-1:0] pc_q, pc_next;
    logic [CW-1:0]   drop_q, drop_next;

    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_inst;
    logic            head_filled;
    logic [CW-1:0]   buf_count;
    logic [CW-1:0]   buf_pending;

    logic req;
    logic alloc;
    logic fill;
    logic pop;
    logic valid;

    // Request is held low while rst is asserted so nothing is issued before
    // the PC has been reloaded.
    assign req   = (state_q == FETCH) && (buf_count < CW'(BUF_DEPTH)) && !i_redirect && !rst;
    assign alloc = req && i_imem_gnt;
    assign valid = head_filled && (state_q == FETCH);
    // Redirect wins: no pop, and the response arriving with it is dropped.
    assign pop   = valid && !i_stall && !i_redirect;
    assign fill  = i_imem_rvalid && (state_q == FETCH) && !i_redirect;

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush       (i_redirect),
        .alloc       (alloc),
        .alloc_pc    (pc_q),
        .fill        (fill),
        .fill_inst   (i_imem_rdata),
        .pop         (pop),
        .head_pc     (head_pc),
        .head_inst   (head_inst),
        .head_filled (head_filled),
        .count       (buf_count),
        .pending     (buf_pending)
    );

    always_comb begin
        state_next = state_q;
        pc_next    = pc_q;
        drop_next  = drop_q;

        if (alloc) begin
            pc_next = pc_q + 32'd4;
        end

        case (state_q)
            FETCH: begin
                if (i_redirect) begin
                    pc_next = align_word(i_redirect_pc);
                    // A response arriving right now belongs to the oldest
                    // unfilled slot, so it is already accounted for.
                    if (i_imem_rvalid && (buf_pending != '0)) begin
                        drop_next = buf_pending - CW'(1);
                    end else begin
                        drop_next = buf_pending;
                    end
                    if (drop_next != '0) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (i_redirect) begin
                    pc_next = align_word(i_redirect_pc);
                end
                if (i_imem_rvalid && (drop_q != '0)) begin
                    drop_next = drop_q - CW'(1);
                end
                if (drop_next == '0) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_next;
            pc_q    <= pc_next;
            drop_q  <= drop_next;
        end
    end

    assign o_imem_req  = req;
    assign o_imem_addr = pc_q;
    assign o_valid     = valid;
    assign o_inst      = valid ? head_inst : INST_NOP;
    assign o_pc        = valid ? head_pc : '0;
    assign o_pc4       = valid ? (head_pc + 32'd4) : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_fetched_q;
    logic [31:0]   perf_stall_q;
    logic [31:0]   perf_flushed_q;
    logic          drop_event;
    logic [CW-1:0] discard_cnt;

    // Each abandoned fetch is counted once: filled slots when the redirect
    // frees them, unfilled ones when their response is thrown away.
    always_comb begin
        drop_event  = 1'b0;
        discard_cnt = '0;
        if ((state_q == FETCH) && i_redirect) begin
            discard_cnt = buf_count - buf_pending;
            drop_event  = i_imem_rvalid && (buf_pending != '0);
        end else if (state_q == DRAIN) begin
            drop_event  = i_imem_rvalid && (drop_q != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(pop);
            perf_stall_q   <= perf_stall_q + 32'(valid && i_stall && !i_redirect);
            perf_flushed_q <= perf_flushed_q + 32'(discard_cnt) + 32'(drop_event);
        end
    end

    assign o_perf_fetched      = perf_fetched_q;
    assign o_perf_stall_cycles = perf_stall_q;
    assign o_perf_flushed      = perf_flushed_q;
`endif

`ifndef SYNTHESIS
    // A response with nothing outstanding is ignored by the logic above, but
    // it indicates a broken memory model or interconnect.
    logic rvalid_orphan;
    assign rvalid_orphan = i_imem_rvalid &&
                           ((state_q == FETCH) ? (buf_pending == '0) : (drop_q == '0));
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst) !rvalid_orphan);
`endif

endmodule
